// File: rtl/rocketcpu_codec_spi_target_if.sv
// Wishbone bus bundle between the CPU and the codec register mirror.
interface rocketcpu_codec_spi_target_if;
  logic [4:0]  i_wb_adr;
  logic [15:0] i_wb_dat;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [15:0] o_wb_dat;
  logic        o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb,
    input  o_wb_dat, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb,
    output o_wb_dat, o_wb_ack
  );
endinterface

// File: rtl/rocketcpu_codec_spi_target.sv
// Codec control-link responder: deserialises 16-bit {addr, data} SPI frames into a
// shadow register file that the CPU reads back over Wishbone.
module rocketcpu_codec_spi_target #(
  parameter int unsigned NREGS       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RESET_ADDR  = 15
) (
  input  logic                        i_wb_clk,
  input  logic                        i_wb_rst_n,
  input  logic                        codec_clk,
  input  logic                        codec_cs,
  input  logic                        codec_di,
  rocketcpu_codec_spi_target_if.slave wb,
  output logic                        o_frame_valid,
  output logic [6:0]                  o_frame_addr,
  output logic [8:0]                  o_frame_data,
  output logic                        o_err
);

  localparam logic [4:0] StatusAdr = 5'd31;
  // Sampled vector order is {cs, clk, di}; cs presets high so a frame in flight at
  // reset release looks busy until the master really drops cs.
  localparam logic [2:0] SmpReset = 3'b100;

  typedef enum logic [1:0] {StWaitIdle, StIdle, StShift, StCommit} state_e;

  logic [2:0] raw;
  logic [2:0] smp;
  logic [2:1] hist_q;

  assign raw = {codec_cs, codec_clk, codec_di};

  if (SYNC_STAGES == 0) begin : g_direct
    assign smp = raw;
  end else begin : g_sync
    logic [2:0] sync_q [SYNC_STAGES];

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SmpReset;
      end else begin
        sync_q[0] <= raw;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign smp = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) hist_q <= SmpReset[2:1];
    else             hist_q <= smp[2:1];
  end

  logic cs_lvl, cs_rise, cs_fall, clk_rise, di_lvl;
  assign cs_lvl   = smp[2];
  assign cs_rise  = smp[2] & ~hist_q[2];
  assign cs_fall  = ~smp[2] & hist_q[2];
  assign clk_rise = smp[1] & ~hist_q[1];
  assign di_lvl   = smp[0];

  state_e      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        commit;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q <= StWaitIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StWaitIdle: begin
        if (!cs_lvl) state_d = StIdle;
      end
      StIdle: begin
        if (cs_rise) begin
          state_d = StShift;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StShift: begin
        // A clk edge seen together with the cs fall belongs to no frame.
        if (cs_fall) begin
          state_d = StCommit;
        end else if (clk_rise) begin
          shift_d = {shift_q[14:0], di_lvl};
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StWaitIdle;
    endcase
  end

  logic [6:0] f_addr;
  logic [8:0] f_data;
  logic       len_ok, do_clear, do_store, do_err;

  assign f_addr   = shift_q[15:9];
  assign f_data   = shift_q[8:0];
  assign len_ok   = (cnt_q == 5'd16);
  assign do_clear = commit & len_ok & (f_addr == 7'(RESET_ADDR));
  assign do_store = commit & len_ok & (f_addr != 7'(RESET_ADDR)) & (32'(f_addr) < NREGS);
  assign do_err   = commit & ~do_clear & ~do_store;

  logic [8:0] regs_q [NREGS];

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (do_clear) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (do_store) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (f_addr == 7'(i)) regs_q[i] <= f_data;
      end
    end
  end

  logic       frame_valid_q;
  logic [6:0] frame_addr_q;
  logic [8:0] frame_data_q;
  logic       err_q;
  logic [6:0] err_cnt_q;
  logic [7:0] good_cnt_q;
  logic       ack_q;
  logic [15:0] wb_dat_q;
  logic       wb_req, clr_err;
  logic [15:0] rd_data;
  logic       unused_wdat;

  assign unused_wdat = ^wb.i_wb_dat[15:1];
  assign wb_req  = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
  assign clr_err = wb_req & wb.i_wb_we & (wb.i_wb_adr == StatusAdr) & wb.i_wb_dat[0];

  // Reads see the register file before any commit landing on the same edge.
  always_comb begin
    rd_data = '0;
    if (wb.i_wb_adr == StatusAdr) begin
      rd_data = {good_cnt_q, err_cnt_q, err_q};
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (wb.i_wb_adr == 5'(i)) rd_data = {7'b0, regs_q[i]};
      end
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      frame_valid_q <= 1'b0;
      frame_addr_q  <= '0;
      frame_data_q  <= '0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
      good_cnt_q    <= '0;
      ack_q         <= 1'b0;
      wb_dat_q      <= '0;
    end else begin
      frame_valid_q <= do_clear | do_store;
      if (do_store) begin
        frame_addr_q <= f_addr;
        frame_data_q <= f_data;
      end
      if (do_clear | do_store) good_cnt_q <= good_cnt_q + 8'd1;

      if (do_err)       err_q <= 1'b1;
      else if (clr_err) err_q <= 1'b0;

      if (clr_err)     err_cnt_q <= do_err ? 7'd1 : 7'd0;
      else if (do_err) err_cnt_q <= err_cnt_q + 7'd1;

      ack_q <= wb_req;
      if (wb_req) wb_dat_q <= rd_data;
    end
  end

  assign o_frame_valid = frame_valid_q;
  assign o_frame_addr  = frame_addr_q;
  assign o_frame_data  = frame_data_q;
  assign o_err         = err_q;
  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_dat   = wb_dat_q;

endmodule

// File: tb/tb_rocketcpu_codec_spi_target.sv
// Bench for the codec register mirror: one instance with direct sampling, one with a
// two-stage synchroniser, checked against a frame-level register-file model.
module tb_rocketcpu_codec_spi_target;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] s_clk = '0;
  logic [1:0] s_cs  = '0;
  logic [1:0] s_di  = '0;
  logic [1:0] fv;
  logic [6:0] fa [2];
  logic [8:0] fd [2];
  logic [1:0] er;

  rocketcpu_codec_spi_target_if wb0 ();
  rocketcpu_codec_spi_target_if wb1 ();

  rocketcpu_codec_spi_target #(.NREGS(16), .SYNC_STAGES(0), .RESET_ADDR(15)) dut_s0 (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n),
    .codec_clk(s_clk[0]), .codec_cs(s_cs[0]), .codec_di(s_di[0]),
    .wb(wb0),
    .o_frame_valid(fv[0]), .o_frame_addr(fa[0]), .o_frame_data(fd[0]), .o_err(er[0])
  );

  rocketcpu_codec_spi_target #(.NREGS(16), .SYNC_STAGES(2), .RESET_ADDR(15)) dut_s2 (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n),
    .codec_clk(s_clk[1]), .codec_cs(s_cs[1]), .codec_di(s_di[1]),
    .wb(wb1),
    .o_frame_valid(fv[1]), .o_frame_addr(fa[1]), .o_frame_data(fd[1]), .o_err(er[1])
  );

  int pulses [2] = '{0, 0};
  always @(negedge clk) begin
    if (fv[0]) pulses[0] <= pulses[0] + 1;
    if (fv[1]) pulses[1] <= pulses[1] + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame-level model: which frames store, clear or fail, and what the bus reads back.
  int m_regs [2][16];
  int m_good [2], m_errc [2], m_err [2], m_faddr [2], m_fdata [2];

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 16; r++) m_regs[s][r] = 0;
      m_good[s] = 0; m_errc[s] = 0; m_err[s] = 0; m_faddr[s] = 0; m_fdata[s] = 0;
    end
  endfunction

  function automatic int model_frame(input int sel, input logic [15:0] word, input int nbits);
    int n = (nbits > 17) ? 17 : nbits;
    int a = int'(word[15:9]);
    int d = int'(word[8:0]);
    if (n == 16 && a == 15) begin
      for (int r = 0; r < 16; r++) m_regs[sel][r] = 0;
      m_good[sel] = (m_good[sel] + 1) % 256;
      return 1;
    end
    if (n == 16 && a < 16) begin
      m_regs[sel][a] = d;
      m_faddr[sel] = a;
      m_fdata[sel] = d;
      m_good[sel] = (m_good[sel] + 1) % 256;
      return 1;
    end
    m_err[sel] = 1;
    m_errc[sel] = (m_errc[sel] + 1) % 128;
    return 0;
  endfunction

  function automatic int model_read(input int sel, input int adr);
    if (adr == 31) return m_good[sel] * 256 + m_errc[sel] * 2 + m_err[sel];
    if (adr < 16) return m_regs[sel][adr];
    return 0;
  endfunction

  function automatic logic get_ack(input int sel);
    return (sel == 0) ? wb0.o_wb_ack : wb1.o_wb_ack;
  endfunction

  function automatic logic [15:0] get_dat(input int sel);
    return (sel == 0) ? wb0.o_wb_dat : wb1.o_wb_dat;
  endfunction

  task automatic wb_drive(input int sel, input logic on, input logic we, input logic [4:0] adr,
                          input logic [15:0] dat);
    if (sel == 0) begin
      wb0.i_wb_cyc = on; wb0.i_wb_stb = on; wb0.i_wb_we = we;
      wb0.i_wb_adr = adr; wb0.i_wb_dat = dat;
    end else begin
      wb1.i_wb_cyc = on; wb1.i_wb_stb = on; wb1.i_wb_we = we;
      wb1.i_wb_adr = adr; wb1.i_wb_dat = dat;
    end
  endtask

  task automatic wb_xfer(input int sel, input logic [4:0] adr, input logic we,
                         input logic [15:0] wdat, output logic [15:0] rdat);
    bit got = 1'b0;
    rdat = 'x;
    wb_drive(sel, 1'b1, we, adr, wdat);
    for (int i = 0; i < 4 && !got; i++) begin
      cyc(1);
      if (get_ack(sel)) begin
        got = 1'b1;
        rdat = get_dat(sel);
      end
    end
    wb_drive(sel, 1'b0, 1'b0, 5'd0, 16'd0);
    check("wb_ack_seen", 32'(got), 32'd1);
    cyc(1);
  endtask

  task automatic read_check(input int sel, input int adr, input int exp, input string name);
    logic [15:0] rd;
    wb_xfer(sel, 5'(adr), 1'b0, 16'd0, rd);
    check(name, 32'(rd), 32'(exp));
  endtask

  function automatic int sync_of(input int sel);
    return (sel == 0) ? 0 : 2;
  endfunction

  function automatic int half_of(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  task automatic send_bits(input int sel, input logic [15:0] word, input int first,
                           input int last, input int half);
    for (int i = first; i < last; i++) begin
      s_di[sel] = (i < 16) ? word[15-i] : 1'($urandom);
      s_clk[sel] = 1'b0;
      cyc(half);
      s_clk[sel] = 1'b1;
      cyc(half);
    end
    s_clk[sel] = 1'b0;
    cyc(half);
  endtask

  task automatic frame(input int sel, input logic [15:0] word, input int nbits);
    s_cs[sel] = 1'b1;
    cyc(sync_of(sel) + 2);
    send_bits(sel, word, 0, nbits, half_of(sel));
    s_cs[sel] = 1'b0;
    cyc(sync_of(sel) + 6);
  endtask

  task automatic frame_checked(input int sel, input logic [15:0] word, input int nbits,
                               input string tag);
    int p0 = pulses[sel];
    int expv;
    frame(sel, word, nbits);
    expv = model_frame(sel, word, nbits);
    check({tag, "_valid"}, 32'(pulses[sel] - p0), 32'(expv));
    check({tag, "_err"}, 32'(er[sel]), 32'(m_err[sel]));
    check({tag, "_addr"}, 32'(fa[sel]), 32'(m_faddr[sel]));
    check({tag, "_data"}, 32'(fd[sel]), 32'(m_fdata[sel]));
  endtask

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          exp_valid;
    logic        exp_err;
    logic [6:0]  exp_addr;
    logic [8:0]  exp_data;
    logic [4:0]  rd_adr;
    logic [15:0] exp_rd;
    bit          clear_after;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] word;
    int p0, expv, adr, nb;

    tbl[0] = '{16'h0E4A, 16, 1, 1'b0, 7'd7, 9'h04A, 5'd7,  16'h004A, 1'b0};
    tbl[1] = '{16'h0E4A, 15, 0, 1'b1, 7'd7, 9'h04A, 5'd31, 16'h0103, 1'b1};
    tbl[2] = '{16'h2201, 16, 0, 1'b1, 7'd7, 9'h04A, 5'd7,  16'h004A, 1'b0};
    tbl[3] = '{16'h1E00, 16, 1, 1'b1, 7'd7, 9'h04A, 5'd7,  16'h0000, 1'b0};
    tbl[4] = '{16'h0A55, 16, 1, 1'b1, 7'd5, 9'h055, 5'd31, 16'h0303, 1'b0};

    wb_drive(0, 1'b0, 1'b0, 5'd0, 16'd0);
    wb_drive(1, 1'b0, 1'b0, 5'd0, 16'd0);
    model_reset();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);

    check("rst_err", 32'(er), 32'd0);
    check("rst_valid", 32'(fv), 32'd0);
    check("rst_addr", 32'(fa[0]), 32'd0);
    check("rst_data", 32'(fd[1]), 32'd0);
    check("rst_ack", 32'(wb0.o_wb_ack), 32'd0);
    read_check(0, 31, 0, "rst_status");

    for (int i = 0; i < 5; i++) begin
      p0 = pulses[0];
      frame(0, tbl[i].word, tbl[i].nbits);
      expv = model_frame(0, tbl[i].word, tbl[i].nbits);
      check($sformatf("vec%0d_valid", i), 32'(pulses[0] - p0), 32'(tbl[i].exp_valid));
      check($sformatf("vec%0d_err", i), 32'(er[0]), 32'(tbl[i].exp_err));
      check($sformatf("vec%0d_addr", i), 32'(fa[0]), 32'(tbl[i].exp_addr));
      check($sformatf("vec%0d_data", i), 32'(fd[0]), 32'(tbl[i].exp_data));
      read_check(0, int'(tbl[i].rd_adr), int'(tbl[i].exp_rd), $sformatf("vec%0d_read", i));
      if (tbl[i].clear_after) begin
        wb_xfer(0, 5'd31, 1'b1, 16'h0001, rd);
        m_err[0] = 0;
        m_errc[0] = 0;
        check($sformatf("vec%0d_clr_err", i), 32'(er[0]), 32'd0);
        read_check(0, 31, 16'h0100, $sformatf("vec%0d_clr_status", i));
      end
    end
    read_check(0, 20, 0, "unmapped_read");
    wb_xfer(0, 5'd5, 1'b1, 16'hFFFF, rd);
    read_check(0, 5, model_read(0, 5), "reg_write_ignored");

    // stb held high: ack must toggle
    wb_drive(0, 1'b1, 1'b0, 5'd7, 16'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check($sformatf("ack_hold%0d", k), 32'(get_ack(0)), 32'((k % 2) == 0));
    end
    wb_drive(0, 1'b0, 1'b0, 5'd0, 16'd0);
    cyc(2);

    // Read of reg 5 issued so it lands on the commit edge of a new value for reg 5.
    word = {7'd5, 9'h1AB};
    p0 = pulses[0];
    s_cs[0] = 1'b1;
    cyc(2);
    send_bits(0, word, 0, 16, 1);
    s_cs[0] = 1'b0;
    cyc(1);
    wb_drive(0, 1'b1, 1'b0, 5'd5, 16'd0);
    cyc(1);
    check("rdcommit_ack", 32'(get_ack(0)), 32'd1);
    check("rdcommit_old", 32'(get_dat(0)), 32'(model_read(0, 5)));
    wb_drive(0, 1'b0, 1'b0, 5'd0, 16'd0);
    cyc(6);
    expv = model_frame(0, word, 16);
    check("rdcommit_valid", 32'(pulses[0] - p0), 32'(expv));
    read_check(0, 5, 16'h01AB, "rdcommit_new");

    // Reset mid-frame, released with cs still high.
    p0 = pulses[0];
    s_cs[0] = 1'b1;
    cyc(2);
    send_bits(0, 16'h0C33, 0, 8, 1);
    rst_n = 1'b0;
    model_reset();
    cyc(2);
    rst_n = 1'b1;
    send_bits(0, 16'h0C33, 8, 16, 1);
    s_cs[0] = 1'b0;
    cyc(6);
    check("midrst_valid", 32'(pulses[0] - p0), 32'd0);
    check("midrst_err", 32'(er[0]), 32'd0);
    check("midrst_addr", 32'(fa[0]), 32'd0);
    read_check(0, 31, 0, "midrst_status");
    read_check(0, 6, 0, "midrst_reg6");
    frame_checked(0, 16'h0E4A, 16, "postrst");
    read_check(0, 7, 16'h004A, "postrst_read");

    // Synchronised instance, 3-cycle half-period, randomised frames.
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || $urandom_range(0, 3) != 0) adr = int'($urandom_range(0, 14));
      else adr = int'($urandom_range(0, 127));
      word = {7'(adr), 9'($urandom)};
      case ($urandom_range(0, 5))
        0: nb = 15;
        1: nb = 17;
        default: nb = 16;
      endcase
      if (i == 0) nb = 16;
      frame_checked(1, word, nb, $sformatf("rnd%0d", i));
      adr = int'($urandom_range(0, 15));
      read_check(1, adr, model_read(1, adr), $sformatf("rnd%0d_read", i));
    end
    read_check(1, 31, model_read(1, 31), "rnd_status");

    // cs fall coincident with a 17th clk rise: the edge is dropped, 16 bits commit.
    word = {7'd3, 9'($urandom)};
    p0 = pulses[1];
    s_cs[1] = 1'b1;
    cyc(4);
    send_bits(1, word, 0, 16, 3);
    s_di[1] = 1'b1;
    s_clk[1] = 1'b1;
    s_cs[1] = 1'b0;
    cyc(3);
    s_clk[1] = 1'b0;
    cyc(8);
    expv = model_frame(1, word, 16);
    check("coinc_valid", 32'(pulses[1] - p0), 32'(expv));
    check("coinc_addr", 32'(fa[1]), 32'd3);
    check("coinc_data", 32'(fd[1]), 32'(m_fdata[1]));
    read_check(1, 3, model_read(1, 3), "coinc_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
